// File: rtl/clk_div_frac_multi.sv
// Multi-channel fractional clock divider: each channel toggles its output every
// N + F/2^CFraW enabled ticks, with glitch-free reload and optional cascade.

module clk_div_frac_ch #(
  parameter int               CIntW   = 8,
  parameter int               CFraW   = 4,
  parameter logic [CIntW-1:0] CIntDef = 8'h09,
  parameter logic [CFraW-1:0] CFraDef = 4'h0,
  parameter logic             CEnDef  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             src,
  input  logic             wr_hit,
  input  logic             wr_en,
  input  logic [CIntW-1:0] wr_n,
  input  logic [CFraW-1:0] wr_f,
  output logic             clk_out,
  output logic             stb,
  output logic             pending
);
  localparam logic [CIntW-1:0] FcntRst = (CIntDef == '0) ? '0 : CIntDef - CIntW'(1);

  logic             en_q, en_d, pend_q, pend_d, fclk_q, fclk_d;
  logic [CIntW-1:0] n_q, n_d, pn_q, pn_d, fcnt_q, fcnt_d, eff_n, load;
  logic [CFraW-1:0] f_q, f_d, pf_q, pf_d, facc_q, facc_d, eff_f;
  logic [CFraW:0]   sum;
  logic             tick, bnd;

  always_comb begin
    tick  = clk_en & en_q & (n_q != '0) & src;
    bnd   = tick & (fcnt_q == '0);
    stb   = bnd & fclk_q;
    // A boundary always reloads from the pending config if one is waiting.
    eff_n = pend_q ? pn_q : n_q;
    eff_f = pend_q ? pf_q : f_q;
    sum   = {1'b0, facc_q} + {1'b0, eff_f};
    load  = eff_n - CIntW'(1) + CIntW'(sum[CFraW]);
    en_d = en_q; n_d = n_q; f_d = f_q; pn_d = pn_q; pf_d = pf_q; pend_d = pend_q;
    fcnt_d = fcnt_q; facc_d = facc_q; fclk_d = fclk_q;
    if (bnd) begin
      n_d    = eff_n;
      f_d    = eff_f;
      pend_d = 1'b0;
      facc_d = sum[CFraW-1:0];
      fcnt_d = (eff_n == '0) ? '0 : load;
      fclk_d = (eff_n != '0) & ~fclk_q;
    end else if (tick) begin
      fcnt_d = fcnt_q - CIntW'(1);
    end
    // A running channel only takes new settings at a boundary; anything else
    // (start from idle, or a stop request) takes effect right away.
    if (wr_hit) begin
      if (!en_q || !wr_en) begin
        en_d   = wr_en;
        n_d    = wr_n;
        f_d    = wr_f;
        fcnt_d = (wr_n == '0) ? '0 : wr_n - CIntW'(1);
        facc_d = '0;
        fclk_d = 1'b0;
        pend_d = 1'b0;
      end else begin
        pn_d   = wr_n;
        pf_d   = wr_f;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= CEnDef; n_q <= CIntDef; f_q <= CFraDef;
      pn_q <= '0; pf_q <= '0; pend_q <= 1'b0;
      fcnt_q <= FcntRst; facc_q <= '0; fclk_q <= 1'b0;
    end else if (clk_en) begin
      en_q <= en_d; n_q <= n_d; f_q <= f_d;
      pn_q <= pn_d; pf_q <= pf_d; pend_q <= pend_d;
      fcnt_q <= fcnt_d; facc_q <= facc_d; fclk_q <= fclk_d;
    end
  end

  assign clk_out = fclk_q;
  assign pending = pend_q;
endmodule

module clk_div_frac_multi #(
  parameter int                CChCnt   = 4,
  parameter int                CChAddrW = 2,
  parameter int                CIntW    = 8,
  parameter int                CFraW    = 4,
  parameter logic [CChCnt-1:0] CCascade = '0,
  parameter logic [CIntW-1:0]  CIntDef  = 8'h09,
  parameter logic [CFraW-1:0]  CFraDef  = 4'h0,
  parameter logic              CEnDef   = 1'b0
) (
  input  logic                   AClkH,
  input  logic                   AResetHN,
  input  logic                   AClkHEn,
  input  logic                   AWrEn,
  input  logic [CChAddrW-1:0]    AWrCh,
  input  logic [CIntW+CFraW:0]   AWrData,
  output logic [CChCnt-1:0]      AClkOut,
  output logic [CChCnt-1:0]      AStb,
  output logic [CChCnt-1:0]      APending
);
  for (genvar i = 0; i < CChCnt; i++) begin : g_ch
    logic src, stb, wr_hit;
    // Cascaded channels tick on the previous channel's strobe in the same cycle.
    if (i == 0) begin : g_src0
      assign src = 1'b1;
    end else begin : g_srcn
      assign src = CCascade[i] ? g_ch[i-1].stb : 1'b1;
    end
    assign wr_hit = AClkHEn & AWrEn & (AWrCh == CChAddrW'(i));

    clk_div_frac_ch #(
      .CIntW(CIntW), .CFraW(CFraW), .CIntDef(CIntDef), .CFraDef(CFraDef), .CEnDef(CEnDef)
    ) u_ch (
      .clk     (AClkH),
      .rst_n   (AResetHN),
      .clk_en  (AClkHEn),
      .src     (src),
      .wr_hit  (wr_hit),
      .wr_en   (AWrData[CIntW+CFraW]),
      .wr_n    (AWrData[CIntW+CFraW-1:CFraW]),
      .wr_f    (AWrData[CFraW-1:0]),
      .clk_out (AClkOut[i]),
      .stb     (stb),
      .pending (APending[i])
    );
    assign AStb[i] = stb;
  end
endmodule

// File: tb/tb_clk_div_frac_multi.sv
// Randomized bench for clk_div_frac_multi against a tick/half-period reference model.

module tb_clk_div_frac_multi;
  localparam int NCH = 3, AW = 2, IW = 8, FW = 4, NDEF = 9, FMOD = 16;
  localparam logic [NCH-1:0] CASC = 3'b010;

  logic AClkH = 1'b0, AResetHN = 1'b0, AClkHEn = 1'b0, AWrEn = 1'b0;
  logic [AW-1:0]    AWrCh = '0;
  logic [IW+FW:0]   AWrData = '0;
  logic [NCH-1:0]   AClkOut, AStb, APending;
  logic [NCH-1:0]   casc_v = CASC;
  int n_cmp = 0, n_bad = 0;

  clk_div_frac_multi #(
    .CChCnt(NCH), .CChAddrW(AW), .CIntW(IW), .CFraW(FW), .CCascade(CASC),
    .CIntDef(8'h09), .CFraDef(4'h0), .CEnDef(1'b0)
  ) dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .AWrEn(AWrEn),
    .AWrCh(AWrCh), .AWrData(AWrData), .AClkOut(AClkOut), .AStb(AStb), .APending(APending)
  );

  always #5 AClkH = ~AClkH;

  // Reference: rem = enabled ticks left in the current half-period.
  int m_en[NCH], m_n[NCH], m_f[NCH], m_pv[NCH], m_pn[NCH], m_pf[NCH];
  int m_rem[NCH], m_acc[NCH], m_lvl[NCH];
  bit m_tick[NCH], m_stb[NCH];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = 0; m_n[i] = NDEF; m_f[i] = 0; m_pv[i] = 0; m_pn[i] = 0; m_pf[i] = 0;
      m_rem[i] = NDEF; m_acc[i] = 0; m_lvl[i] = 0; m_tick[i] = 0; m_stb[i] = 0;
    end
  endfunction

  function automatic void model_comb();
    for (int i = 0; i < NCH; i++) begin
      bit src;
      src = (i > 0 && casc_v[i]) ? m_stb[i-1] : 1'b1;
      m_tick[i] = AClkHEn && AResetHN && m_en[i] != 0 && m_n[i] != 0 && src;
      m_stb[i]  = m_tick[i] && m_rem[i] == 1 && m_lvl[i] != 0;
    end
  endfunction

  function automatic void model_seq();
    if (!AClkHEn || !AResetHN) return;
    for (int i = 0; i < NCH; i++) begin
      int was_en, wen, wn, wf;
      was_en = m_en[i];
      if (m_tick[i]) begin
        if (m_rem[i] == 1) begin
          if (m_pv[i] != 0) begin m_n[i] = m_pn[i]; m_f[i] = m_pf[i]; m_pv[i] = 0; end
          m_acc[i] = m_acc[i] + m_f[i];
          m_rem[i] = m_n[i] + m_acc[i] / FMOD;
          m_acc[i] = m_acc[i] % FMOD;
          m_lvl[i] = (m_n[i] == 0) ? 0 : 1 - m_lvl[i];
        end else m_rem[i]--;
      end
      if (AWrEn && AWrCh == i) begin
        wen = int'(AWrData[IW+FW]); wn = int'(AWrData[IW+FW-1:FW]); wf = int'(AWrData[FW-1:0]);
        if (was_en == 0 || wen == 0) begin
          m_en[i] = wen; m_n[i] = wn; m_f[i] = wf; m_rem[i] = wn;
          m_acc[i] = 0; m_lvl[i] = 0; m_pv[i] = 0;
        end else begin
          m_pn[i] = wn; m_pf[i] = wf; m_pv[i] = 1;
        end
      end
    end
  endfunction

  function automatic logic [NCH-1:0] exp_clk();
    for (int i = 0; i < NCH; i++) exp_clk[i] = (m_lvl[i] != 0);
  endfunction
  function automatic logic [NCH-1:0] exp_stb();
    for (int i = 0; i < NCH; i++) exp_stb[i] = m_stb[i];
  endfunction
  function automatic logic [NCH-1:0] exp_pnd();
    for (int i = 0; i < NCH; i++) exp_pnd[i] = (m_pv[i] != 0);
  endfunction

  task automatic wr(input int ch, input int en, input int n, input int f);
    AWrEn = 1'b1; AWrCh = ch[AW-1:0]; AWrData = {en[0], n[IW-1:0], f[FW-1:0]};
  endtask

  task automatic cyc_pre();
    @(negedge AClkH);
    model_comb();
  endtask

  task automatic cyc_post();
    model_seq();
    @(posedge AClkH);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    n_cmp++; if (AClkOut !== '0) begin n_bad++; $display("FAIL reset_clk got %b want 000", AClkOut); end
    n_cmp++; if (AStb !== '0) begin n_bad++; $display("FAIL reset_stb got %b want 000", AStb); end
    n_cmp++; if (APending !== '0) begin n_bad++; $display("FAIL reset_pnd got %b want 000", APending); end
    @(posedge AClkH); #1;
    AResetHN = 1'b1; AClkHEn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      AWrEn = 1'b0;
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL idle_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL idle_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      cyc_post();
    end
  endtask

  task automatic test_basic();
    int last = -1;
    for (int c = 0; c < 40; c++) begin
      AWrEn = 1'b0;
      if (c == 0) wr(0, 1, 3, 0);
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL basic_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL basic_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      if (AStb[0]) begin
        if (last >= 0) begin
          n_cmp++; if (c - last != 6) begin n_bad++; $display("FAIL basic_period got %0d want 6", c - last); end
        end
        last = c;
      end
      cyc_post();
    end
  endtask

  task automatic test_frac();
    int last = -1;
    for (int c = 0; c < 60; c++) begin
      AWrEn = 1'b0;
      if (c == 0) wr(0, 0, 2, 8);
      if (c == 1) wr(0, 1, 2, 8);
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL frac_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL frac_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      if (AStb[0]) begin
        if (last >= 0) begin
          n_cmp++; if (c - last != 5) begin n_bad++; $display("FAIL frac_period got %0d want 5", c - last); end
        end
        last = c;
      end
      cyc_post();
    end
  endtask

  task automatic test_reload();
    for (int c = 0; c < 40; c++) begin
      AWrEn = 1'b0;
      case (c)
        0:  wr(0, 0, 3, 0);
        1:  wr(0, 1, 3, 0);
        9:  wr(0, 1, 5, 0);
        35: wr(0, 0, 5, 0);
        default: ;
      endcase
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL reload_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL reload_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      n_cmp++; if (APending !== exp_pnd()) begin n_bad++; $display("FAIL reload_pnd c%0d got %b want %b", c, APending, exp_pnd()); end
      if (c == 10) begin
        n_cmp++; if (APending[0] !== 1'b1) begin n_bad++; $display("FAIL reload_pend_set got %b want 1", APending[0]); end
      end
      if (c == 36) begin
        n_cmp++; if (AClkOut[0] !== 1'b0) begin n_bad++; $display("FAIL disable_drop got %b want 0", AClkOut[0]); end
      end
      cyc_post();
    end
  endtask

  task automatic test_cascade();
    int rise = -1;
    logic prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      AWrEn = 1'b0;
      case (c)
        0: wr(0, 0, 1, 0);
        1: wr(1, 0, 2, 0);
        2: wr(0, 1, 1, 0);
        3: wr(1, 1, 2, 0);
        default: ;
      endcase
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL casc_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL casc_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      if (AClkOut[1] && !prev) begin
        if (rise >= 0) begin
          n_cmp++; if (c - rise != 8) begin n_bad++; $display("FAIL casc_period got %0d want 8", c - rise); end
        end
        rise = c;
      end
      prev = AClkOut[1];
      cyc_post();
    end
  endtask

  task automatic test_clken();
    for (int c = 0; c < 40; c++) begin
      AWrEn = 1'b0;
      AClkHEn = (c < 2) ? 1'b1 : logic'(c % 2);
      if (c == 0) wr(0, 0, 1, 0);
      if (c == 1) wr(0, 1, 1, 0);
      if (c >= 2 && !AClkHEn) wr($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15));
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL clken_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL clken_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      n_cmp++; if (APending !== exp_pnd()) begin n_bad++; $display("FAIL clken_pnd c%0d got %b want %b", c, APending, exp_pnd()); end
      cyc_post();
    end
    AClkHEn = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      AWrEn = 1'b0;
      AClkHEn = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0)
        wr($urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 5), $urandom_range(0, 15));
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL rand_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL rand_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      n_cmp++; if (APending !== exp_pnd()) begin n_bad++; $display("FAIL rand_pnd c%0d got %b want %b", c, APending, exp_pnd()); end
      cyc_post();
    end
    AClkHEn = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 30; c++) begin
      AWrEn = 1'b0;
      case (c)
        0:  wr(0, 0, 2, 3);
        1:  wr(0, 1, 2, 3);
        2:  wr(2, 0, 4, 0);
        3:  wr(2, 1, 4, 0);
        4:  wr(0, 1, 6, 0);
        6: begin
          AResetHN = 1'b0;
          #2;
          n_cmp++; if (AClkOut !== '0) begin n_bad++; $display("FAIL rstmid_clk got %b want 000", AClkOut); end
          n_cmp++; if (AStb !== '0) begin n_bad++; $display("FAIL rstmid_stb got %b want 000", AStb); end
          n_cmp++; if (APending !== '0) begin n_bad++; $display("FAIL rstmid_pnd got %b want 000", APending); end
          model_reset();
        end
        7:  AResetHN = 1'b1;
        10: wr(3, 1, 4, 4);
        14: wr(0, 1, 4, 0);
        default: ;
      endcase
      cyc_pre();
      n_cmp++; if (AClkOut !== exp_clk()) begin n_bad++; $display("FAIL rstmid_run_clk c%0d got %b want %b", c, AClkOut, exp_clk()); end
      n_cmp++; if (AStb !== exp_stb()) begin n_bad++; $display("FAIL rstmid_run_stb c%0d got %b want %b", c, AStb, exp_stb()); end
      n_cmp++; if (APending !== exp_pnd()) begin n_bad++; $display("FAIL rstmid_run_pnd c%0d got %b want %b", c, APending, exp_pnd()); end
      cyc_post();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_reload();
    test_cascade();
    test_clken();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
